// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Digit-serial signed adder/subtractor. It computes
//               rd = rs + rt (op=0) or rd = rs - rt (op=1). The block
//               handles DIGIT bits per clock, LSB first, and uses a
//               start/busy/done handshake. Results are bit-exact with a
//               combinational two's-complement add/sub.
// Options     : SERIAL_ADDSUB_OVF_EN - when defined, ovf reports the signed
//               overflow of the last completed op. When undefined, ovf is
//               tied low and no overflow logic exists.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1   // must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // Number of RUN cycles per operation.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   r_sh_q,  r_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   rd_q,    rd_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // Sum of the current digit. The extra top bit is the digit carry-out.
  logic [DIGIT:0]     w_digit_sum;
  logic [WIDTH-1:0]   w_a_shr;
  logic [WIDTH-1:0]   w_b_shr;
  logic [WIDTH-1:0]   w_r_shin;
  logic               w_last;

  // Ripple-add one digit of each operand together with the running carry.
  assign w_digit_sum = (DIGIT+1)'(a_sh_q[DIGIT-1:0])
                     + (DIGIT+1)'(b_sh_q[DIGIT-1:0])
                     + (DIGIT+1)'(carry_q);

  assign w_last = (cnt_q == CNT_LAST);

  // Operand shift-down and result shift-in. The degenerate single-digit
  // case has no bits left to shift, so it needs its own wiring.
  generate
    if (DIGIT < WIDTH) begin : g_shift
      assign w_a_shr  = {{DIGIT{1'b0}}, a_sh_q[WIDTH-1:DIGIT]};
      assign w_b_shr  = {{DIGIT{1'b0}}, b_sh_q[WIDTH-1:DIGIT]};
      assign w_r_shin = {w_digit_sum[DIGIT-1:0], r_sh_q[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign w_a_shr  = '0;
      assign w_b_shr  = '0;
      assign w_r_shin = w_digit_sum[DIGIT-1:0];
    end
  endgenerate

  // Next-state logic for the control FSM and the serial datapath.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d  = rs;
          b_sh_d  = op ? ~rt : rt;
          carry_d = op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d  = w_a_shr;
        b_sh_d  = w_b_shr;
        r_sh_d  = w_r_shin;
        carry_d = w_digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (w_last) begin
          // Publish the finished word. The final carry-out is dropped.
          rd_d    = w_r_shin;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd   = rd_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  logic w_msb_cin;

  // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign w_msb_cin = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ w_digit_sum[DIGIT-1];

  // Signed overflow is captured only on the completing edge, alongside rd.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == RUN) && w_last) begin
      ovf_d = w_msb_cin ^ w_digit_sum[DIGIT];
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH=32, DIGIT=1 and
//               DIGIT=4) against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op;
  logic [31:0] rs, rt;
  logic [31:0] rd;
  logic        busy, done, ovf;

  logic        start4, op4;
  logic [31:0] rs4, rt4;
  logic [31:0] rd4;
  logic        busy4, done4, ovf4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(32), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .busy(busy), .done(done), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(32), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .rs(rs4), .rt(rt4),
    .rd(rd4), .busy(busy4), .done(done4), .ovf(ovf4)
  );

  // Reference model: signed integer arithmetic, wrapped to 32 bits.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic o);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = o ? (sa - sb) : (sa + sb);
    return r[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic o);
`ifdef SERIAL_ADDSUB_OVF_EN
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = o ? (sa - sb) : (sa + sb);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Launch one op on the selected instance. Return the result and the latency
  // in edges, plus the number of sampled cycles with busy high.
  task automatic run_op(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input bit noise,
                        output logic [31:0] r, output logic v,
                        output int lat, output int bcnt, output bit tmo);
    @(negedge clk);
    if (sel4) begin rs4 = a; rt4 = b; op4 = o; start4 = 1'b1; end
    else      begin rs  = a; rt  = b; op  = o; start  = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start  = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!(sel4 ? done4 : done) && lat < 200) begin
      if (sel4 ? busy4 : busy) bcnt++;
      if (noise && !sel4) begin
        rs = $urandom; rt = $urandom; op = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    tmo = (lat >= 200);
    r = sel4 ? rd4 : rd;
    v = sel4 ? ovf4 : ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; op = 1'b0; rs = '0; rt = '0;
    start4 = 1'b0; op4 = 1'b0; rs4 = '0; rt4 = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd, busy, done, ovf} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_d1: rd=%h busy=%b done=%b ovf=%b, required all zero", rd, busy, done, ovf);
    end
    n_cmp++;
    if ({rd4, busy4, done4, ovf4} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_d4: rd=%h busy=%b done=%b ovf=%b, required all zero", rd4, busy4, done4, ovf4);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta[6] = '{32'h1C71C71C, 32'h00000001, 32'h00000001, 32'h7FFFFFFF,
                           32'h80000000, 32'hFFFFFFF9};
    logic [31:0] tb[6] = '{32'h1C71C71C, 32'h80000000, 32'h80000000, 32'h00000001,
                           32'h00000001, 32'h00000002};
    logic        to[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] r;
    logic        v;
    int lat, bcnt;
    bit tmo;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, ta[i], tb[i], to[i], 1'b0, r, v, lat, bcnt, tmo);
      n_cmp++;
      if (tmo || r !== ref_sum(ta[i], tb[i], to[i])) begin
        n_bad++;
        $display("FAIL directed_rd[%0d]: got %h, required %h (timeout=%0b)", i, r, ref_sum(ta[i], tb[i], to[i]), tmo);
      end
      n_cmp++;
      if (v !== ref_ovf(ta[i], tb[i], to[i])) begin
        n_bad++;
        $display("FAIL directed_ovf[%0d]: got %b, required %b", i, v, ref_ovf(ta[i], tb[i], to[i]));
      end
      n_cmp++;
      if (lat != 32 || bcnt != 32) begin
        n_bad++;
        $display("FAIL directed_timing[%0d]: latency %0d busy %0d, required 32/32", i, lat, bcnt);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || rd !== r) begin
        n_bad++;
        $display("FAIL directed_pulse[%0d]: done=%b rd=%h, required done=0 rd=%h", i, done, rd, r);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic        o, v;
    int lat, bcnt;
    bit tmo;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; o = 1'($urandom_range(0, 1));
      if (i % 8 == 0) a = 32'h80000000;
      if (i % 8 == 1) b = 32'h7FFFFFFF;
      run_op(1'b0, a, b, o, 1'b1, r, v, lat, bcnt, tmo);
      n_cmp++;
      if (tmo || r !== ref_sum(a, b, o) || v !== ref_ovf(a, b, o) || lat != 32) begin
        n_bad++;
        $display("FAIL random[%0d]: a=%h b=%h op=%b got rd=%h ovf=%b lat=%0d, required rd=%h ovf=%b lat=32",
                 i, a, b, o, r, v, lat, ref_sum(a, b, o), ref_ovf(a, b, o));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ndone, bad_hold;
    @(negedge clk);
    rs = 32'd5; rt = 32'd3; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    ndone = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin rs = 32'd100; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (rd !== 32'h00000008 || lat != 32) begin
      n_bad++;
      $display("FAIL b2b_first: rd=%h lat=%0d, required rd=00000008 lat=32", rd, lat);
    end
    // New request presented while done is high.
    rs = 32'h12345678; rt = 32'h11111111; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bad_hold = 0;
    while (!done && lat < 200) begin
      if (rd !== 32'h00000008) bad_hold++;
      if (busy !== 1'b1) bad_hold++;
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (bad_hold != 0) begin
      n_bad++;
      $display("FAIL b2b_hold: %0d samples with rd not held or busy low, required 0", bad_hold);
    end
    n_cmp++;
    if (rd !== 32'h01234567 || lat != 32) begin
      n_bad++;
      $display("FAIL b2b_second: rd=%h lat=%0d, required rd=01234567 lat=32", rd, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL b2b_single_done: %0d extra done pulses, required 0", ndone);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r;
    logic        v;
    int lat, bcnt, ndone;
    bit tmo;
    @(negedge clk);
    rs = 32'hFFFFFFF9; rt = 32'd2; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: rd=%h busy=%b done=%b ovf=%b, required all zero", rd, busy, done, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL midrun_no_done: %0d cycles with done/busy after abort, required 0", ndone);
    end
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, r, v, lat, bcnt, tmo);
    n_cmp++;
    if (tmo || r !== 32'hFFFFFFF7 || v !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_recover: rd=%h ovf=%b, required FFFFFFF7 / 0", r, v);
    end
  endtask

  task automatic test_digit4();
    logic [31:0] a, b, r;
    logic        o, v;
    int lat, bcnt;
    bit tmo;
    run_op(1'b1, 32'h0000000F, 32'h00000001, 1'b0, 1'b0, r, v, lat, bcnt, tmo);
    n_cmp++;
    if (tmo || r !== 32'h00000010 || lat != 8 || bcnt != 8) begin
      n_bad++;
      $display("FAIL digit4_basic: rd=%h lat=%0d busy=%0d, required 00000010 / 8 / 8", r, lat, bcnt);
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; o = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h7FFFFFFF; b = 32'h00000001; o = 1'b0; end
      if (i == 1) begin a = 32'h80000000; b = 32'h00000001; o = 1'b1; end
      run_op(1'b1, a, b, o, 1'b0, r, v, lat, bcnt, tmo);
      n_cmp++;
      if (tmo || r !== ref_sum(a, b, o) || v !== ref_ovf(a, b, o) || lat != 8) begin
        n_bad++;
        $display("FAIL digit4_random[%0d]: a=%h b=%h op=%b got rd=%h ovf=%b lat=%0d, required rd=%h ovf=%b lat=8",
                 i, a, b, o, r, v, lat, ref_sum(a, b, o), ref_ovf(a, b, o));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_digit4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
